fifo_sample_unpacker: RTL

//  Read-side consumer of the mixed-clock FIFO; runs entirely in the clk_get domain.

---
 rtl/fifo_sample_unpacker.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fifo_sample_unpacker.sv
// Read-side FIFO consumer: fetches 32-bit stereo words and streams them out as two 16-bit samples.
// Optional sticky underrun output when UNPACK_UNDERRUN_EN is defined.
module fifo_sample_unpacker #(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int BUF_DEPTH    = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk_get,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    empty,
  input  logic [DATA_WIDTH-1:0]   data_get,
  output logic                    req_get,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SAMPLE_WIDTH-1:0] out_sample,
  output logic                    out_chan,
  output logic [CNT_WIDTH-1:0]    sample_count
`ifdef UNPACK_UNDERRUN_EN
  ,
  output logic                    underrun
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CH0,
    S_CH1
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] head;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [OW-1:0]         occ;
  logic                  inflight;
  logic                  credit_ok;
  logic                  accept;
  logic                  pop;
  logic                  wr;

  // Credit counts the in-flight word so the buffer can never overflow.
  assign credit_ok = (occ + OW'(inflight)) < OW'(BUF_DEPTH);
  assign req_get   = !reset && enable && !empty && credit_ok;
  assign wr        = inflight;
  assign accept    = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  always_comb begin
    state_nxt  = state;
    out_valid  = 1'b0;
    out_chan   = 1'b0;
    out_sample = '0;
    pop        = 1'b0;
    case (state)
      // With an empty buffer the arriving word is presented straight from data_get.
      S_IDLE: begin
        if (inflight) begin
          out_valid  = 1'b1;
          out_sample = data_get[SAMPLE_WIDTH-1:0];
          state_nxt  = out_ready ? S_CH1 : S_CH0;
        end
      end
      S_CH0: begin
        out_valid  = 1'b1;
        out_sample = head[SAMPLE_WIDTH-1:0];
        if (out_ready) state_nxt = S_CH1;
      end
      S_CH1: begin
        out_valid  = 1'b1;
        out_chan   = 1'b1;
        out_sample = head[DATA_WIDTH-1:SAMPLE_WIDTH];
        if (out_ready) begin
          pop       = 1'b1;
          state_nxt = (occ > OW'(1) || inflight) ? S_CH0 : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_get or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      inflight     <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      occ          <= '0;
      sample_count <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= req_get;
      if (wr)  wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({wr, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
      if (accept) sample_count <= sample_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_get) begin
    if (wr) mem[wr_ptr] <= data_get;
  end

`ifdef UNPACK_UNDERRUN_EN
  always_ff @(posedge clk_get or posedge reset) begin
    if (reset) begin
      underrun <= 1'b0;
    end else if (out_ready && !out_valid && enable && (sample_count != '0)) begin
      underrun <= 1'b1;
    end
  end
`endif

endmodule
